change_dispenser: RTL and testbench

//  Consumes the 3-bit change code from the change decoder and drives the coin hopper.

---
 rtl/change_dispenser_if.sv | 25 ++
 rtl/change_dispenser.sv | 117 +++++++++++
 tb/tb_change_dispenser.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/change_dispenser_if.sv
// Change-dispenser handshake bundle: change-code intake from the decoder
// plus the hopper eject/ack lines and job status.
interface change_dispenser_if;
   logic       change_valid;
   logic [2:0] change;
   logic       change_ready;
   logic       dime_out;
   logic       nickel_out;
   logic       hopper_ack;
   logic       busy;
   logic       done;
   logic       fault;

   // Driver side (decoder + hopper model)
   modport master (
      output change_valid, change, hopper_ack,
      input  change_ready, dime_out, nickel_out, busy, done, fault
   );

   // Dispenser side
   modport slave (
      input  change_valid, change, hopper_ack,
      output change_ready, dime_out, nickel_out, busy, done, fault
   );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: turns a 3-bit change bitmask into timed eject pulses for
// the coin hopper, one coin at a time (dimes first), waiting for the hopper's
// coin-sensed ack per coin. A missing ack aborts the job with a sticky fault.
module change_dispenser #(
   parameter int PULSE_CYC   = 4,
   parameter int GAP_CYC     = 2,
   parameter int ACK_TIMEOUT = 16
) (
   input logic              clk,
   input logic              rst,
   change_dispenser_if.slave bus
);
   localparam int M1      = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int CNT_MAX = (M1 > ACK_TIMEOUT) ? M1 : ACK_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_NEXT, S_PULSE, S_WAIT_ACK, S_GAP, S_FAULT, S_DONE
   } state_t;

   state_t          r_state, w_next;
   logic [CW-1:0]   r_tmr;
   logic [1:0]      r_dime_cnt;
   logic            r_nick_cnt;
   logic            r_sel_dime;
   logic            r_ack_seen;
   logic            r_fault;
   logic            w_xfer;
   logic            w_ack;

   assign w_xfer = (r_state == S_IDLE) && bus.change_valid;
   // An ack seen during the pulse counts the same as one seen while waiting.
   assign w_ack  = bus.hopper_ack || r_ack_seen;

   // State register; reset aborts any job immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:     if (w_xfer) w_next = S_NEXT;
         S_NEXT:     if (r_dime_cnt != 2'd0 || r_nick_cnt) w_next = S_PULSE;
                     else                                   w_next = S_DONE;
         S_PULSE:    if (r_tmr == '0) w_next = S_WAIT_ACK;
         S_WAIT_ACK: if (w_ack)                w_next = S_GAP;
                     else if (r_tmr == '0)     w_next = S_FAULT;
         S_GAP:      if (r_tmr == '0) w_next = S_NEXT;
         S_FAULT:    w_next = S_IDLE;
         S_DONE:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Phase timer: reloaded on every state change, counts down to 0 and holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmr <= '0;
      end else if (w_next != r_state) begin
         unique case (w_next)
            S_PULSE:    r_tmr <= CW'(PULSE_CYC - 1);
            S_WAIT_ACK: r_tmr <= CW'(ACK_TIMEOUT - 1);
            S_GAP:      r_tmr <= CW'(GAP_CYC - 1);
            default:    r_tmr <= '0;
         endcase
      end else if (r_tmr != '0) begin
         r_tmr <= r_tmr - CW'(1);
      end
   end

   // Job bookkeeping: coin counts, selected coin, early-ack latch, fault flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dime_cnt <= 2'd0;
         r_nick_cnt <= 1'b0;
         r_sel_dime <= 1'b0;
         r_ack_seen <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_dime_cnt <= {bus.change[2], 1'b0} + {1'b0, bus.change[1]};
            r_nick_cnt <= bus.change[0];
            r_fault    <= 1'b0;
         end
         if (r_state == S_NEXT && w_next == S_PULSE) begin
            r_sel_dime <= (r_dime_cnt != 2'd0);
            r_ack_seen <= 1'b0;
         end
         if (r_state == S_PULSE && bus.hopper_ack)
            r_ack_seen <= 1'b1;
         // One decrement per coin regardless of how many ack cycles arrived.
         if (r_state == S_WAIT_ACK && w_next == S_GAP) begin
            r_ack_seen <= 1'b0;
            if (r_sel_dime) r_dime_cnt <= r_dime_cnt - 2'd1;
            else            r_nick_cnt <= 1'b0;
         end
         // Set on entry so fault rises together with the FAULT-cycle done.
         if (r_state == S_WAIT_ACK && w_next == S_FAULT)
            r_fault <= 1'b1;
         if (r_state == S_FAULT) begin
            r_dime_cnt <= 2'd0;
            r_nick_cnt <= 1'b0;
         end
      end
   end

   // Moore outputs decoded straight from state so reset drops them at once.
   assign bus.change_ready = (r_state == S_IDLE);
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.done         = (r_state == S_DONE) || (r_state == S_FAULT);
   assign bus.dime_out     = (r_state == S_PULSE) &&  r_sel_dime;
   assign bus.nickel_out   = (r_state == S_PULSE) && !r_sel_dime;
   assign bus.fault        = r_fault;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: walks the reset, empty-job, full-job,
// timeout, early-ack, mid-job reset and busy-ignore scenarios in one sequence.
module tb_change_dispenser;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   change_dispenser_if bus();

   change_dispenser #(.PULSE_CYC(4), .GAP_CYC(2), .ACK_TIMEOUT(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Passive monitor sampled on the falling edge.
   int   m_dime = 0, m_nick = 0, m_done = 0, m_both = 0, m_done_rdy = 0;
   logic p_dime = 1'b0, p_nick = 1'b0, p_done = 1'b0;
   always @(negedge clk) begin
      if (bus.dime_out   && !p_dime) m_dime = m_dime + 1;
      if (bus.nickel_out && !p_nick) m_nick = m_nick + 1;
      if (bus.done       && !p_done) m_done = m_done + 1;
      if (bus.dime_out && bus.nickel_out) m_both = m_both + 1;
      if (bus.done && bus.change_ready)   m_done_rdy = m_done_rdy + 1;
      p_dime = bus.dime_out;
      p_nick = bus.nickel_out;
      p_done = bus.done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the next eject pulse, optionally holding ack high
   // during it; returns in the first cycle after the pulse falls.
   task automatic wait_pulse(input bit ack_in_pulse, output bit is_dime,
                             output int idle, output int width);
      idle  = 0;
      width = 0;
      while (!(bus.dime_out || bus.nickel_out) && idle < 60) begin
         idle++;
         tick();
      end
      is_dime = bus.dime_out;
      bus.hopper_ack = ack_in_pulse;
      while ((bus.dime_out || bus.nickel_out) && width < 60) begin
         width++;
         tick();
      end
      bus.hopper_ack = 1'b0;
   endtask

   task automatic ack_pulse();
      bus.hopper_ack = 1'b1;
      tick();
      bus.hopper_ack = 1'b0;
   endtask

   initial begin
      bit d;
      int idle, w, s_dime, s_nick, s_done;
      bus.change_valid = 1'b0;
      bus.change       = 3'b000;
      bus.hopper_ack   = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_ready", bus.change_ready, 1);
      chk("rst_busy",  bus.busy, 0);
      chk("rst_done",  bus.done, 0);
      chk("rst_fault", bus.fault, 0);
      chk("rst_eject", {bus.dime_out, bus.nickel_out}, 0);
      rst = 1'b0;
      tick();

      // 1: code 000 -> done at E+2, ready back at E+3
      s_dime = m_dime; s_nick = m_nick;
      bus.change_valid = 1'b1; bus.change = 3'b000;
      tick();
      bus.change_valid = 1'b0;
      chk("t1_busy_e1",  bus.busy, 1);
      chk("t1_ready_e1", bus.change_ready, 0);
      chk("t1_done_e1",  bus.done, 0);
      tick();
      chk("t1_done_e2",  bus.done, 1);
      chk("t1_ready_e2", bus.change_ready, 0);
      tick();
      chk("t1_done_e3",  bus.done, 0);
      chk("t1_ready_e3", bus.change_ready, 1);
      chk("t1_fault",    bus.fault, 0);
      chk("t1_no_eject", (m_dime - s_dime) + (m_nick - s_nick), 0);

      // 2: code 111 -> 3 dimes then 1 nickel
      s_done = m_done;
      bus.change_valid = 1'b1; bus.change = 3'b111;
      tick();
      bus.change_valid = 1'b0;
      wait_pulse(1'b0, d, idle, w);
      chk("t2_c0_dime", d, 1); chk("t2_c0_idle", idle, 1); chk("t2_c0_w", w, 4);
      ack_pulse();
      wait_pulse(1'b0, d, idle, w);
      chk("t2_c1_dime", d, 1); chk("t2_c1_idle", idle, 3); chk("t2_c1_w", w, 4);
      ack_pulse();
      wait_pulse(1'b0, d, idle, w);
      chk("t2_c2_dime", d, 1); chk("t2_c2_idle", idle, 3); chk("t2_c2_w", w, 4);
      ack_pulse();
      wait_pulse(1'b0, d, idle, w);
      chk("t2_c3_nick", d, 0); chk("t2_c3_idle", idle, 3); chk("t2_c3_w", w, 4);
      ack_pulse();
      tick(); tick(); tick();
      chk("t2_done",  bus.done, 1);
      chk("t2_fault", bus.fault, 0);
      tick();
      chk("t2_ready", bus.change_ready, 1);
      chk("t2_ndone", m_done - s_done, 1);

      // 3: code 010, no ack -> timeout fault; then 001 clears it
      bus.change_valid = 1'b1; bus.change = 3'b010;
      tick();
      bus.change_valid = 1'b0;
      wait_pulse(1'b0, d, idle, w);
      chk("t3_dime", d, 1); chk("t3_w", w, 4);
      repeat (15) tick();
      chk("t3_wait_busy", bus.busy, 1);
      chk("t3_wait_done", bus.done, 0);
      chk("t3_wait_flt",  bus.fault, 0);
      tick();
      chk("t3_flt_done",  bus.done, 1);
      chk("t3_flt_fault", bus.fault, 1);
      tick();
      chk("t3_idle_done",  bus.done, 0);
      chk("t3_idle_fault", bus.fault, 1);
      chk("t3_idle_ready", bus.change_ready, 1);
      tick();
      chk("t3_sticky", bus.fault, 1);
      bus.change_valid = 1'b1; bus.change = 3'b001;
      tick();
      bus.change_valid = 1'b0;
      chk("t3_fault_clr", bus.fault, 0);
      wait_pulse(1'b0, d, idle, w);
      chk("t3_nick", d, 0); chk("t3_nick_w", w, 4);
      ack_pulse();
      tick(); tick(); tick();
      chk("t3_done2", bus.done, 1);
      tick();

      // 4: code 100, ack held during each pulse -> WAIT_ACK lasts one cycle
      s_dime = m_dime; s_nick = m_nick;
      bus.change_valid = 1'b1; bus.change = 3'b100;
      tick();
      bus.change_valid = 1'b0;
      wait_pulse(1'b1, d, idle, w);
      chk("t4_c0_dime", d, 1); chk("t4_c0_w", w, 4);
      wait_pulse(1'b1, d, idle, w);
      chk("t4_c1_dime", d, 1); chk("t4_c1_idle", idle, 4); chk("t4_c1_w", w, 4);
      tick(); tick(); tick(); tick();
      chk("t4_done",  bus.done, 1);
      chk("t4_fault", bus.fault, 0);
      chk("t4_ndime", m_dime - s_dime, 2);
      chk("t4_nnick", m_nick - s_nick, 0);
      tick();

      // 5: reset in the 2nd cycle of a dime pulse
      bus.change_valid = 1'b1; bus.change = 3'b100;
      tick();
      bus.change_valid = 1'b0;
      tick(); tick();
      chk("t5_pulse_on", bus.dime_out, 1);
      rst = 1'b1;
      #1;
      chk("t5_dime_off", bus.dime_out, 0);
      chk("t5_busy",     bus.busy, 0);
      chk("t5_ready",    bus.change_ready, 1);
      tick();
      rst = 1'b0;
      s_dime = m_dime; s_nick = m_nick;
      repeat (20) tick();
      chk("t5_no_eject", (m_dime - s_dime) + (m_nick - s_nick), 0);
      chk("t5_idle",     bus.busy, 0);

      // 6: valid held high with changing codes while busy
      s_dime = m_dime; s_nick = m_nick;
      bus.change_valid = 1'b1; bus.change = 3'b100;
      tick();
      bus.change = 3'b111;
      wait_pulse(1'b0, d, idle, w);
      chk("t6_c0_dime", d, 1);
      bus.change = 3'b001;
      ack_pulse();
      wait_pulse(1'b0, d, idle, w);
      chk("t6_c1_dime", d, 1);
      ack_pulse();
      tick(); tick(); tick();
      chk("t6_done",  bus.done, 1);
      chk("t6_ndime", m_dime - s_dime, 2);
      chk("t6_nnick", m_nick - s_nick, 0);
      tick();
      chk("t6_ready", bus.change_ready, 1);
      tick();
      bus.change_valid = 1'b0;
      chk("t6_accept", bus.busy, 1);
      wait_pulse(1'b0, d, idle, w);
      chk("t6_nick", d, 0); chk("t6_nick_idle", idle, 1);
      ack_pulse();
      tick(); tick(); tick();
      chk("t6_done2", bus.done, 1);
      tick();

      // Global invariants gathered by the monitor
      chk("never_both_eject", m_both, 0);
      chk("never_done_ready", m_done_rdy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
